// File: rtl/fp_pkg.sv
// Shared floating-point types, constants and field helpers.
// Used by fp_mul_seq and main_div.
package fp_pkg;

    localparam int EXP_W  = 8;
    localparam int MANT_W = 23;
    localparam int DATA_W = 1 + EXP_W + MANT_W;
    localparam int BIAS   = (1 << (EXP_W - 1)) - 1;

    localparam logic [DATA_W-1:0] QNAN = 32'h7FC00000;

    typedef enum logic [2:0] {
        IDLE,
        UNPACK,
        MULT,
        NORM,
        DONE
    } state_t;

    typedef struct packed {
        logic              sign;
        logic [EXP_W-1:0]  exp;
        logic [MANT_W-1:0] frac;
    } fp_t;

    function automatic fp_t fp_unpack(input logic [DATA_W-1:0] x);
        return fp_t'(x);
    endfunction

    // Denormals are flushed, so a zero exponent means zero.
    function automatic logic fp_is_zero(input logic [EXP_W-1:0] e);
        return e == '0;
    endfunction

    function automatic logic fp_is_inf(
        input logic [EXP_W-1:0]  e,
        input logic [MANT_W-1:0] f
    );
        return (&e) && (f == '0);
    endfunction

    function automatic logic fp_is_nan(
        input logic [EXP_W-1:0]  e,
        input logic [MANT_W-1:0] f
    );
        return (&e) && (f != '0);
    endfunction

endpackage

// File: rtl/fp_mant_shiftadd.sv
// Shift-add mantissa multiplier, one multiplier bit per clock.
// start loads operands; done marks the edge of the final step.
module fp_mant_shiftadd #(
    parameter int W = 24
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [W-1:0]   mcand,
    input  logic [W-1:0]   mplier,
    output logic           busy,
    output logic           done,
    output logic [2*W-1:0] prod
);

    localparam int CW = $clog2(W);

    logic [2*W-1:0] mc_q;
    logic [W-1:0]   mp_q;
    logic [2*W-1:0] acc_q;
    logic [CW-1:0]  cnt_q;
    logic           busy_q;

    assign busy = busy_q;
    assign done = busy_q && (cnt_q == CW'(W - 1));
    assign prod = acc_q;

    // Load on start, then add the shifted multiplicand per set bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            mc_q   <= '0;
            mp_q   <= '0;
            acc_q  <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
        end else if (start) begin
            mc_q   <= {{W{1'b0}}, mcand};
            mp_q   <= mplier;
            acc_q  <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b1;
        end else if (busy_q) begin
            acc_q <= acc_q + (mp_q[0] ? mc_q : '0);
            mc_q  <= mc_q << 1;
            mp_q  <= mp_q >> 1;
            cnt_q <= cnt_q + 1'b1;
            if (done) begin
                busy_q <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/fp_mul_seq.sv
// Iterative single-precision multiplier with valid/ready handshakes.
// Define FP_MUL_RNE_EN for round-to-nearest-even; default truncates.
module fp_mul_seq #(
    parameter int DATA_WIDTH = 32,
    parameter int EXP_W      = 8,
    parameter int MANT_W     = 23
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [DATA_WIDTH-1:0] m,
    output logic                  overflow,
    output logic                  underflow,
    output logic                  out_valid,
    input  logic                  out_ready
);

    import fp_pkg::*;

    localparam int W  = MANT_W + 1;
    localparam int PW = 2 * W;
    localparam int EW = EXP_W + 2;

    localparam logic signed [EW-1:0] E_MAX  = EW'((1 << EXP_W) - 1);
    localparam logic signed [EW-1:0] E_BIAS = EW'(BIAS);
    localparam logic signed [EW-1:0] E_ZERO = '0;

    state_t state_q;
    state_t state_d;

    fp_t a_q;
    fp_t b_q;

    logic                  sign_q;
    logic signed [EW-1:0]  exp_q;
    logic                  spec_q;
    logic [DATA_WIDTH-1:0] spec_m_q;
    logic [DATA_WIDTH-1:0] m_q;
    logic                  ov_q;
    logic                  un_q;

    logic a_zero, a_inf, a_nan;
    logic b_zero, b_inf, b_nan;
    logic c_nan, c_inf, c_zero;
    logic special;
    logic s;
    logic signed [EW-1:0] exp_sum;
    logic [DATA_WIDTH-1:0] spec_m;

    logic           mul_start;
    logic           mul_busy;
    logic           mul_done;
    logic [PW-1:0]  prod;

    logic                 hi;
    logic signed [EW-1:0] e_n;
    logic signed [EW-1:0] e_r;
    logic [MANT_W-1:0]    frac_t;
    logic [MANT_W-1:0]    frac_r;

    logic [DATA_WIDTH-1:0] res_m;
    logic                  res_ov;
    logic                  res_un;

    logic unused_busy;

    assign a_zero = fp_is_zero(a_q.exp);
    assign b_zero = fp_is_zero(b_q.exp);
    assign a_inf  = fp_is_inf(a_q.exp, a_q.frac);
    assign b_inf  = fp_is_inf(b_q.exp, b_q.frac);
    assign a_nan  = fp_is_nan(a_q.exp, a_q.frac);
    assign b_nan  = fp_is_nan(b_q.exp, b_q.frac);

    assign c_nan  = a_nan | b_nan | (a_inf & b_zero) | (b_inf & a_zero);
    assign c_inf  = (a_inf | b_inf) & ~c_nan;
    assign c_zero = (a_zero | b_zero) & ~c_nan & ~c_inf;

    assign special = c_nan | c_inf | c_zero;
    assign s       = a_q.sign ^ b_q.sign;
    assign exp_sum = $signed({2'b00, a_q.exp})
                   + $signed({2'b00, b_q.exp})
                   - E_BIAS;

    // Canned result for operands that bypass the multiplier.
    always_comb begin
        spec_m = '0;
        unique case (1'b1)
            c_nan:   spec_m = QNAN;
            c_inf:   spec_m = {s, {EXP_W{1'b1}}, {MANT_W{1'b0}}};
            c_zero:  spec_m = {s, {(DATA_WIDTH-1){1'b0}}};
            default: spec_m = '0;
        endcase
    end

    assign mul_start   = (state_q == UNPACK) && !special;
    assign unused_busy = mul_busy;

    fp_mant_shiftadd #(
        .W (W)
    ) u_core (
        .clk    (clk),
        .rst    (rst),
        .start  (mul_start),
        .mcand  ({1'b1, a_q.frac}),
        .mplier ({1'b1, b_q.frac}),
        .busy   (mul_busy),
        .done   (mul_done),
        .prod   (prod)
    );

    assign hi     = prod[PW-1];
    assign e_n    = exp_q + $signed({{(EW-1){1'b0}}, hi});
    assign frac_t = hi ? prod[PW-2 -: MANT_W] : prod[PW-3 -: MANT_W];

`ifdef FP_MUL_RNE_EN
    logic               g_bit;
    logic               r_bit;
    logic               st_bit;
    logic               inc;
    logic [MANT_W+1:0]  rnd;

    assign g_bit  = hi ? prod[W-1] : prod[W-2];
    assign r_bit  = hi ? prod[W-2] : prod[W-3];
    assign st_bit = hi ? (|prod[W-3:0]) : (|prod[W-4:0]);
    assign inc    = g_bit & (r_bit | st_bit | frac_t[0]);
    assign rnd    = {2'b01, frac_t} + {{(MANT_W+1){1'b0}}, inc};
    assign frac_r = rnd[MANT_W+1] ? '0 : rnd[MANT_W-1:0];
    assign e_r    = e_n + $signed({{(EW-1){1'b0}}, rnd[MANT_W+1]});
`else
    logic unused_tail;

    assign unused_tail = |prod[W-2:0];
    assign frac_r      = frac_t;
    assign e_r         = e_n;
`endif

    // Pack the result and saturate to inf or zero on exponent range.
    always_comb begin
        res_m  = {sign_q, e_r[EXP_W-1:0], frac_r};
        res_ov = 1'b0;
        res_un = 1'b0;
        if (spec_q) begin
            res_m = spec_m_q;
        end else if (e_r >= E_MAX) begin
            res_m  = {sign_q, {EXP_W{1'b1}}, {MANT_W{1'b0}}};
            res_ov = 1'b1;
        end else if (e_r <= E_ZERO) begin
            res_m  = {sign_q, {(DATA_WIDTH-1){1'b0}}};
            res_un = 1'b1;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state; specials skip MULT and just pick up the canned result in NORM.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (in_valid) state_d = UNPACK;
            UNPACK:  state_d = special ? NORM : MULT;
            MULT:    if (mul_done) state_d = NORM;
            NORM:    state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Operand capture, unpack results and the held output word.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_q      <= '0;
            b_q      <= '0;
            sign_q   <= 1'b0;
            exp_q    <= '0;
            spec_q   <= 1'b0;
            spec_m_q <= '0;
            m_q      <= '0;
            ov_q     <= 1'b0;
            un_q     <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        a_q <= fp_unpack(a);
                        b_q <= fp_unpack(b);
                    end
                end
                UNPACK: begin
                    sign_q   <= s;
                    exp_q    <= exp_sum;
                    spec_q   <= special;
                    spec_m_q <= spec_m;
                end
                NORM: begin
                    m_q  <= res_m;
                    ov_q <= res_ov;
                    un_q <= res_un;
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign m         = m_q;
    assign overflow  = ov_q;
    assign underflow = un_q;

endmodule

// File: tb/tb_fp_mul_seq.sv
// Directed vector bench for fp_mul_seq.
// Table of products plus backpressure and mid-op reset sequences.
module tb_fp_mul_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] a;
    logic [31:0] b;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] m;
    logic        overflow;
    logic        underflow;
    logic        out_valid;
    logic        out_ready;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] m;
        logic        ov;
        logic        un;
        int          lat;
    } vec_t;

    vec_t vt [15];

    always #5 clk = ~clk;

    fp_mul_seq dut (
        .clk       (clk),
        .rst       (rst),
        .a         (a),
        .b         (b),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .m         (m),
        .overflow  (overflow),
        .underflow (underflow),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic run_op(input logic [31:0] xa, input logic [31:0] xb,
                          output int lat);
        int n;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        a        = xa;
        b        = xb;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lat      = 0;
        while (!out_valid && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic take(input string nm);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk({nm, "_in_ready"}, 32'(in_ready), 32'd1);
        chk({nm, "_out_valid"}, 32'(out_valid), 32'd0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int seen;
        string nm;

        vt[0]  = '{32'h40000000, 32'h40400000, 32'h40C00000, 1'b0, 1'b0, 26};
        vt[1]  = '{32'h7F000000, 32'h40000000, 32'h7F800000, 1'b1, 1'b0, 26};
        vt[2]  = '{32'h00800000, 32'h3F000000, 32'h00000000, 1'b0, 1'b1, 26};
        vt[3]  = '{32'h80000000, 32'h40400000, 32'h80000000, 1'b0, 1'b0, 2};
        vt[4]  = '{32'h7F800000, 32'h00000000, 32'h7FC00000, 1'b0, 1'b0, 2};
`ifdef FP_MUL_RNE_EN
        vt[5]  = '{32'h3FC00001, 32'h3FC00001, 32'h40100002, 1'b0, 1'b0, 26};
`else
        vt[5]  = '{32'h3FC00001, 32'h3FC00001, 32'h40100001, 1'b0, 1'b0, 26};
`endif
        vt[6]  = '{32'h3FC00000, 32'h3FC00000, 32'h40100000, 1'b0, 1'b0, 26};
        vt[7]  = '{32'h7FC00000, 32'h3F800000, 32'h7FC00000, 1'b0, 1'b0, 2};
        vt[8]  = '{32'hFF800000, 32'h40000000, 32'hFF800000, 1'b0, 1'b0, 2};
        vt[9]  = '{32'h3F800000, 32'hBF800000, 32'hBF800000, 1'b0, 1'b0, 26};
        vt[10] = '{32'h00400000, 32'h40000000, 32'h00000000, 1'b0, 1'b0, 2};
        vt[11] = '{32'h7F400000, 32'h3FC00000, 32'h7F800000, 1'b1, 1'b0, 26};
        vt[12] = '{32'h7F000000, 32'h3F800000, 32'h7F000000, 1'b0, 1'b0, 26};
        vt[13] = '{32'h00800000, 32'h3F800000, 32'h00800000, 1'b0, 1'b0, 26};
        vt[14] = '{32'h3F800000, 32'h3F800000, 32'h3F800000, 1'b0, 1'b0, 26};

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_m", m, 32'h0);
        chk("rst_ov", 32'(overflow), 32'd0);
        chk("rst_un", 32'(underflow), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 15; i++) begin
            nm = $sformatf("v%0d", i);
            run_op(vt[i].a, vt[i].b, lat);
            chk({nm, "_lat"}, 32'(lat), 32'(vt[i].lat));
            chk({nm, "_m"}, m, vt[i].m);
            chk({nm, "_ov"}, 32'(overflow), 32'(vt[i].ov));
            chk({nm, "_un"}, 32'(underflow), 32'(vt[i].un));
            take(nm);
        end

        run_op(32'h40000000, 32'h40400000, lat);
        chk("bp_lat", 32'(lat), 32'd26);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            in_valid = 1'b1;
            a        = 32'h3F800000;
            b        = 32'h3F800000;
            @(posedge clk);
            #1;
            chk("bp_m", m, 32'h40C00000);
            chk("bp_ov", 32'(overflow), 32'd0);
            chk("bp_un", 32'(underflow), 32'd0);
            chk("bp_in_ready", 32'(in_ready), 32'd0);
            chk("bp_out_valid", 32'(out_valid), 32'd1);
        end
        @(negedge clk);
        in_valid = 1'b0;
        take("bp");
        @(posedge clk);
        #1;
        chk("bp_idle_valid", 32'(out_valid), 32'd0);

        @(negedge clk);
        a        = 32'h40000000;
        b        = 32'h40400000;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (11) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("mrst_in_ready", 32'(in_ready), 32'd1);
        chk("mrst_out_valid", 32'(out_valid), 32'd0);
        chk("mrst_m", m, 32'h0);
        @(negedge clk);
        rst  = 1'b0;
        seen = 0;
        repeat (30) begin
            @(posedge clk);
            #1;
            if (out_valid) seen++;
        end
        chk("mrst_no_valid", 32'(seen), 32'd0);
        run_op(32'h3FC00000, 32'h3FC00000, lat);
        chk("mrst_lat", 32'(lat), 32'd26);
        chk("mrst_m2", m, 32'h40100000);
        take("mrst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
